// File: rtl/halt_dump_unit.sv
// Halt detector and register dump engine: watches the committed PC, stops on the
// halt address or the cycle limit, then streams every register out over valid/ready.
module halt_dump_unit #(
    parameter logic [31:0] HALT_PC     = 32'h00020000,
    parameter int          CYCLE_LIMIT = 1000,
    parameter int          CNT_W       = 16,
    parameter int          NREG        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      pc_in,
    input  logic [4:0]       dbg_sel,
    output logic [4:0]       reg_sel,
    input  logic [31:0]      reg_data,
    output logic             dump_valid,
    input  logic             dump_ready,
    output logic [4:0]       dump_idx,
    output logic [31:0]      dump_data,
    output logic [CNT_W-1:0] cycle_count,
    output logic             halted,
    output logic             halt_cause,
    output logic             done
);

    localparam logic [2:0] S_RUN     = 3'd0;
    localparam logic [2:0] S_SELECT  = 3'd1;
    localparam logic [2:0] S_CAPTURE = 3'd2;
    localparam logic [2:0] S_SEND    = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLE_LIMIT - 1);
    localparam logic [4:0]       IDX_LAST = 5'(NREG - 1);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cycle_count_q, cycle_count_d;
    logic             halted_q, halted_d;
    logic             halt_cause_q, halt_cause_d;
    logic             done_q, done_d;
    logic             dump_valid_q, dump_valid_d;
    logic [4:0]       dump_idx_q, dump_idx_d;
    logic [31:0]      dump_data_q, dump_data_d;
    logic [4:0]       index_q, index_d;

    always_comb begin
        state_d       = state_q;
        cycle_count_d = cycle_count_q;
        halted_d      = halted_q;
        halt_cause_d  = halt_cause_q;
        done_d        = done_q;
        dump_valid_d  = dump_valid_q;
        dump_idx_d    = dump_idx_q;
        dump_data_d   = dump_data_q;
        index_d       = index_q;
        case (state_q)
            S_RUN: begin
                // PC match is tested first so it wins over a coincident timeout
                if (pc_in == HALT_PC) begin
                    state_d      = S_SELECT;
                    halted_d     = 1'b1;
                    halt_cause_d = 1'b0;
                end else if (cycle_count_q == CNT_LAST) begin
                    state_d      = S_SELECT;
                    halted_d     = 1'b1;
                    halt_cause_d = 1'b1;
                end else begin
                    cycle_count_d = cycle_count_q + 1'b1;
                end
            end
            S_SELECT: state_d = S_CAPTURE;
            S_CAPTURE: begin
                dump_data_d  = (index_q == 5'd0) ? 32'h0 : reg_data;
                dump_idx_d   = index_q;
                dump_valid_d = 1'b1;
                state_d      = S_SEND;
            end
            S_SEND: begin
                if (dump_ready) begin
                    dump_valid_d = 1'b0;
                    if (index_q == IDX_LAST) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        index_d = index_q + 1'b1;
                        state_d = S_SELECT;
                    end
                end
            end
            S_DONE: state_d = S_DONE;
            default: state_d = S_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_RUN;
            cycle_count_q <= '0;
            halted_q      <= 1'b0;
            halt_cause_q  <= 1'b0;
            done_q        <= 1'b0;
            dump_valid_q  <= 1'b0;
            dump_idx_q    <= 5'd0;
            dump_data_q   <= 32'h0;
            index_q       <= 5'd0;
        end else begin
            state_q       <= state_d;
            cycle_count_q <= cycle_count_d;
            halted_q      <= halted_d;
            halt_cause_q  <= halt_cause_d;
            done_q        <= done_d;
            dump_valid_q  <= dump_valid_d;
            dump_idx_q    <= dump_idx_d;
            dump_data_q   <= dump_data_d;
            index_q       <= index_d;
        end
    end

    // The register-file port belongs to the debugger except while dumping
    assign reg_sel     = (state_q == S_SELECT || state_q == S_CAPTURE || state_q == S_SEND)
                         ? index_q : dbg_sel;
    assign dump_valid  = dump_valid_q;
    assign dump_idx    = dump_idx_q;
    assign dump_data   = dump_data_q;
    assign cycle_count = cycle_count_q;
    assign halted      = halted_q;
    assign halt_cause  = halt_cause_q;
    assign done        = done_q;

endmodule

// File: tb/tb_halt_dump_unit.sv
// Randomized bench for halt_dump_unit: a cycle-level behavioural model is compared
// against the DUT every cycle, with literal checks on the key scenarios.
module tb_halt_dump_unit;
    localparam logic [31:0] HALT_PC = 32'h00020000;
    localparam int LIMIT = 1000;
    localparam int NREG  = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc_in = 32'h0;
    logic [4:0]  dbg_sel = 5'd0;
    logic [4:0]  reg_sel;
    logic [31:0] reg_data;
    logic        dump_valid;
    logic        dump_ready = 1'b0;
    logic [4:0]  dump_idx;
    logic [31:0] dump_data;
    logic [15:0] cycle_count;
    logic        halted, halt_cause, done;

    logic [31:0] rf [NREG];
    assign reg_data = rf[reg_sel];

    halt_dump_unit #(.HALT_PC(HALT_PC), .CYCLE_LIMIT(LIMIT), .CNT_W(16), .NREG(NREG)) dut (
        .clk(clk), .rst(rst), .pc_in(pc_in), .dbg_sel(dbg_sel), .reg_sel(reg_sel),
        .reg_data(reg_data), .dump_valid(dump_valid), .dump_ready(dump_ready),
        .dump_idx(dump_idx), .dump_data(dump_data), .cycle_count(cycle_count),
        .halted(halted), .halt_cause(halt_cause), .done(done)
    );

    initial forever #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    int unsigned tcyc  = 0;

    // Model: m_age counts cycles into the current entry; from age 2 the entry is offered
    int          m_cnt, m_k, m_age;
    bit          m_halted, m_cause, m_done;
    logic [31:0] m_data;

    logic [4:0]  q_idx [$];
    logic [31:0] q_dat [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, tcyc);
        end
    endtask

    function automatic void m_reset();
        m_cnt = 0; m_k = 0; m_age = 0;
        m_halted = 0; m_cause = 0; m_done = 0;
        m_data = 32'h0;
    endfunction

    task automatic compare();
        bit exp_v;
        if (rst) m_reset();
        exp_v = m_halted && !m_done && m_age >= 2;
        chk("halted", 32'(halted), 32'(m_halted));
        chk("halt_cause", 32'(halt_cause), 32'(m_cause));
        chk("done", 32'(done), 32'(m_done));
        chk("cycle_count", 32'(cycle_count), 32'(m_cnt));
        chk("dump_valid", 32'(dump_valid), 32'(exp_v));
        if (exp_v) begin
            chk("dump_idx", 32'(dump_idx), 32'(m_k));
            chk("dump_data", dump_data, m_data);
        end else if (!m_halted) begin
            chk("dump_idx_idle", 32'(dump_idx), 32'h0);
            chk("dump_data_idle", dump_data, 32'h0);
        end
        if (!m_halted || m_done) chk("reg_sel_pass", 32'(reg_sel), 32'(dbg_sel));
        else if (m_age < 2)      chk("reg_sel_idx", 32'(reg_sel), 32'(m_k));
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk);
            tcyc++;
            if (rst) m_reset();
            else if (!m_halted) begin
                if (pc_in == HALT_PC) begin
                    m_halted = 1; m_cause = 0; m_k = 0; m_age = 0;
                end else if (m_cnt == LIMIT - 1) begin
                    m_halted = 1; m_cause = 1; m_k = 0; m_age = 0;
                end else m_cnt++;
            end else if (!m_done) begin
                if (m_age >= 2) begin
                    if (dump_ready) begin
                        if (m_k == NREG - 1) m_done = 1;
                        else begin m_k++; m_age = 0; end
                    end
                end else begin
                    if (m_age == 1) m_data = (m_k == 0) ? 32'h0 : rf[m_k];
                    m_age++;
                end
            end
            #2;
            compare();
        end
    end

    // Record what the DUT actually hands over
    initial forever begin
        @(negedge clk);
        if (rst) begin
            q_idx.delete(); q_dat.delete();
        end else if (dump_valid && dump_ready) begin
            q_idx.push_back(dump_idx); q_dat.push_back(dump_data);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    function automatic logic [31:0] rand_pc();
        logic [31:0] p;
        p = $urandom;
        if (p == HALT_PC) p = 32'h4;
        return p;
    endfunction

    task automatic do_reset();
        rst = 1'b1; pc_in = 32'h0; dump_ready = 1'b0;
        repeat (2) cyc();
        rst = 1'b0;
    endtask

    task automatic rand_rf();
        for (int i = 0; i < NREG; i++) rf[i] = $urandom;
        rf[0] = rf[0] | 32'h1;
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            pc_in = rand_pc(); dbg_sel = 5'($urandom); dump_ready = 1'($urandom);
            cyc();
        end
    endtask

    task automatic run_to_done(input int pct);
        int g;
        g = 0;
        while (!done && g < 3000) begin
            pc_in = ($urandom_range(0, 3) == 0) ? HALT_PC : rand_pc();
            dbg_sel = 5'($urandom);
            dump_ready = ($urandom_range(0, 99) < pct);
            cyc(); g++;
        end
        chk("done_reached", 32'(done), 32'h1);
    endtask

    task automatic check_seq();
        chk("entry_count", 32'(q_idx.size()), 32'(NREG));
        for (int i = 0; i < NREG && i < q_idx.size(); i++) begin
            chk("seq_idx", 32'(q_idx[i]), 32'(i));
            chk("seq_data", q_dat[i], (i == 0) ? 32'h0 : rf[i]);
        end
    endtask

    initial begin
        int unsigned h0, d0;
        int n, g, c3;

        // PC halt path
        for (int i = 0; i < NREG; i++) rf[i] = 32'(i) * 32'h0101;
        do_reset();
        chk("rst_halted", 32'(halted), 32'h0);
        chk("rst_valid", 32'(dump_valid), 32'h0);
        chk("rst_count", 32'(cycle_count), 32'h0);
        run_cycles(10);
        dbg_sel = 5'd7; #1;
        chk("pass_run", 32'(reg_sel), 32'd7);
        pc_in = HALT_PC; dump_ready = 1'b1;
        cyc();
        h0 = tcyc;
        chk("pc_halted", 32'(halted), 32'h1);
        chk("pc_cause", 32'(halt_cause), 32'h0);
        chk("pc_count", 32'(cycle_count), 32'd10);
        g = 0;
        while (!done && g < 200) begin
            pc_in = ($urandom_range(0, 1) == 0) ? HALT_PC : rand_pc();
            dbg_sel = 5'($urandom);
            cyc(); g++;
        end
        d0 = tcyc;
        chk("pc_done", 32'(done), 32'h1);
        chk("done_latency", 32'(d0 - h0), 32'd96);
        check_seq();
        if (q_dat.size() > 5) chk("data5_literal", q_dat[5], 32'h0505);
        if (q_dat.size() > 0) chk("data0_literal", q_dat[0], 32'h0);
        dbg_sel = 5'd7; #1;
        chk("pass_done", 32'(reg_sel), 32'd7);

        // Timeout path
        rand_rf();
        do_reset();
        n = 0;
        while (!halted && n < 1100) begin
            pc_in = rand_pc(); dbg_sel = 5'($urandom); dump_ready = 1'($urandom);
            cyc(); n++;
        end
        chk("timeout_cycles", 32'(n), 32'd1000);
        chk("timeout_count", 32'(cycle_count), 32'd999);
        chk("timeout_cause", 32'(halt_cause), 32'h1);
        run_to_done(50);
        chk("timeout_count_hold", 32'(cycle_count), 32'd999);
        check_seq();

        // PC match coincident with the last RUN cycle
        rand_rf();
        do_reset();
        run_cycles(LIMIT - 1);
        pc_in = HALT_PC;
        cyc();
        chk("simul_halted", 32'(halted), 32'h1);
        chk("simul_cause", 32'(halt_cause), 32'h0);
        chk("simul_count", 32'(cycle_count), 32'd999);
        run_to_done(70);
        check_seq();

        // Backpressure on entry 3
        rand_rf();
        do_reset();
        run_cycles(3);
        pc_in = HALT_PC; dump_ready = 1'b1;
        cyc();
        pc_in = rand_pc();
        g = 0;
        while (!(dump_valid && dump_idx == 5'd3) && g < 100) begin cyc(); g++; end
        dump_ready = 1'b0;
        repeat (7) begin
            chk("bp_valid", 32'(dump_valid), 32'h1);
            chk("bp_idx", 32'(dump_idx), 32'd3);
            chk("bp_data", dump_data, rf[3]);
            cyc();
        end
        dump_ready = 1'b1;
        cyc();
        dump_ready = 1'b0;
        c3 = 0;
        foreach (q_idx[i]) if (q_idx[i] == 5'd3) c3++;
        chk("bp_one_xfer", 32'(c3), 32'd1);
        chk("bp_xfers", 32'(q_idx.size()), 32'd4);
        repeat (4) cyc();
        chk("bp_next_valid", 32'(dump_valid), 32'h1);
        chk("bp_next_idx", 32'(dump_idx), 32'd4);
        run_to_done(100);
        check_seq();

        // Reset in the middle of the dump
        rand_rf();
        do_reset();
        run_cycles(5);
        pc_in = HALT_PC;
        cyc();
        pc_in = rand_pc();
        g = 0;
        while (!(dump_valid && dump_idx == 5'd17) && g < 500) begin
            dump_ready = 1'($urandom); cyc(); g++;
        end
        chk("mid_reached17", 32'(dump_idx), 32'd17);
        rst = 1'b1; #1;
        chk("mid_valid", 32'(dump_valid), 32'h0);
        chk("mid_halted", 32'(halted), 32'h0);
        chk("mid_count", 32'(cycle_count), 32'h0);
        repeat (2) cyc();
        rst = 1'b0;
        run_cycles(4);
        pc_in = HALT_PC;
        cyc();
        run_to_done(60);
        check_seq();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/halt_dump_unit.md
Name: halt_dump_unit

Overview:
- Sits directly downstream of the CPU top (sccomp). Watches the committed PC every cycle.
- Detects program end, either by PC reaching the halt address or by the cycle limit expiring.
- Once halted, walks reg_sel through every architectural register and captures reg_data.
- Streams each (index, value) pair out over a valid/ready port to the result logger. This replaces ad-hoc end-of-run register dumping with a reusable, synthesizable block.

Parameters:
- HALT_PC, 32'h00020000: PC value that marks normal program end.
- CYCLE_LIMIT, 1000: RUN cycles before a forced timeout halt.
- CNT_W, 16: width of the cycle counter. CYCLE_LIMIT must be less than 2^CNT_W.
- NREG, 32: number of registers dumped, indices 0..NREG-1. Must be 32 or less.

Ports:
- clk, in, 1: clock, rising edge.
- rst, in, 1: asynchronous, active-high reset.
- pc_in, in, 32: current CPU PC.
- dbg_sel, in, 5: debug register select, passed through when not dumping.
- reg_sel, out, 5: register select driven to the CPU register-file read port.
- reg_data, in, 32: register-file read data. Combinational in reg_sel, valid in the same cycle.
- dump_valid, out, 1: dump_idx/dump_data hold a valid entry.
- dump_ready, in, 1: consumer accepts the entry.
- dump_idx, out, 5: register index of the current entry.
- dump_data, out, 32: register value of the current entry.
- cycle_count, out, CNT_W: RUN cycles elapsed.
- halted, out, 1: a halt has been detected (RUN has been left).
- halt_cause, out, 1: 0 = PC match, 1 = timeout.
- done, out, 1: all NREG entries have been accepted.

Behaviour:
- Reset (async, rst=1) values:
  - state = RUN.
  - cycle_count = 0, halted = 0, halt_cause = 0, done = 0.
  - dump_valid = 0, dump_idx = 0, dump_data = 0.
  - Internal index = 0.
  - reg_sel = dbg_sel (combinational passthrough in RUN).
- RUN:
  - Each cycle, if pc_in == HALT_PC, go to SELECT with halt_cause = 0 and halted = 1.
  - Else if cycle_count == CYCLE_LIMIT-1, go to SELECT with halt_cause = 1 and halted = 1.
  - Else cycle_count += 1.
  - A PC match wins over a simultaneous timeout (cause 0).
  - cycle_count never exceeds CYCLE_LIMIT-1 and freezes on leaving RUN.
- SELECT:
  - reg_sel = index. Next state is CAPTURE.
- CAPTURE:
  - reg_sel = index.
  - Register dump_data = (index == 0) ? 32'h0 : reg_data, so $0 always reads as zero.
  - dump_idx = index, dump_valid = 1. Next state is SEND.
- SEND:
  - dump_valid stays at 1. dump_idx/dump_data are stable until accepted.
  - Transfer happens in a cycle where dump_valid & dump_ready.
  - On transfer, dump_valid drops to 0 on the next edge.
  - If index == NREG-1, go to DONE; else index += 1 and go to SELECT.
  - No bubble-free streaming is required. The minimum is 3 cycles per entry (SELECT, CAPTURE, SEND with ready=1).
- DONE:
  - done = 1 and dump_valid = 0.
  - reg_sel returns to dbg_sel passthrough.
  - halted, halt_cause and cycle_count hold. The state is sticky until rst.
- pc_in is ignored in every state except RUN. A second PC match after halting has no effect.
- dump_ready is ignored while dump_valid = 0.
- Reset mid-dump: all outputs return immediately to their reset values and the dump restarts from RUN. No partial entry is held.
- Index wrap: the index never exceeds NREG-1.
- Latency from the halt condition being seen in RUN to the first dump_valid is 2 edges.
- Full dump time with dump_ready tied high is 3*NREG cycles.

Test Plan:
- PC halt path: pc_in reaches 32'h00020000 at RUN cycle 10, rf[i] = i*16'h0101, dump_ready = 1.
  - Expect halted = 1, halt_cause = 0, cycle_count = 10.
  - Expect 32 entries with idx 0..31, data[0] = 0 and data[5] = 32'h0505.
  - Expect done = 1 exactly 96 cycles after halt.
- Timeout path: pc_in never matches, CYCLE_LIMIT = 1000.
  - Expect halt after 1000 RUN cycles, cycle_count = 999, halt_cause = 1.
- Simultaneous: pc_in == HALT_PC on the same cycle cycle_count == CYCLE_LIMIT-1.
  - Expect halt_cause = 0.
- Backpressure: hold dump_ready = 0 for 7 cycles on entry idx 3, then pulse it for 1 cycle.
  - Expect dump_valid, dump_idx = 3 and dump_data stable throughout, and exactly one transfer.
  - Expect the next entry to be idx 4, with no skipped or duplicated index.
- Reset mid-dump: assert rst during SEND of idx 17, then release.
  - Expect immediate dump_valid = 0, halted = 0, cycle_count = 0.
  - Expect the next halt to dump starting from idx 0.
- Passthrough: in RUN and DONE, drive dbg_sel = 7.
  - Expect reg_sel = 7 combinationally.
  - During SELECT/CAPTURE, expect reg_sel = the internal index regardless of dbg_sel.
